// File: rtl/instr_mem_loader.sv
// Byte-stream loader for instruction memory: packs little-endian bytes into words,
// writes them at consecutive word addresses and stalls the CPU until the image is in.
module instr_mem_loader #(
   parameter int N     = 32,
   parameter int DEPTH = 256,
   parameter int LW    = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic [LW-1:0] load_len,
   input  logic [7:0]    byte_data,
   input  logic          byte_valid,
   output logic          byte_ready,
   output logic          mem_we,
   output logic [N-1:0]  mem_address,
   output logic [N-1:0]  mem_wdata,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic          cpu_hold
);

   typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} stateT;

   stateT         state, nextState;
   logic [1:0]    byteIdx;
   logic [LW-1:0] wordIdx;
   logic [LW-1:0] loadLenQ;
   logic [N-9:0]  asmWord;
   logic [N-1:0]  addrQ;
   logic [N-1:0]  dataQ;
   logic          errorQ;

   logic startOk;
   logic lenTooBig;
   logic xfer;
   logic lastWord;

   // abort takes priority over a simultaneous start
   assign startOk   = start && !abort && (state == IDLE || state == DONE);
   assign lenTooBig = load_len > LW'(DEPTH);
   assign xfer      = byte_valid && (state == RECV);
   assign lastWord  = wordIdx == (loadLenQ - LW'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         // NOTE: sequential state is updated with non-blocking assignments only,
         // so every flop samples the pre-edge values of its neighbours.
         state <= nextState;
      end
   end

   always_comb begin
      // NOTE: default first; any path that skips an assignment holds state
      // explicitly instead of inferring a latch.
      nextState = state;
      unique case (state)
         IDLE, DONE: begin
            if (startOk && !lenTooBig)
               nextState = (load_len == '0) ? DONE : RECV;
         end
         RECV: begin
            if (abort)
               nextState = IDLE;
            else if (xfer && byteIdx == 2'd3)
               nextState = WRITE;
         end
         WRITE: begin
            if (abort)
               nextState = IDLE;
            else
               nextState = lastWord ? DONE : RECV;
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byteIdx  <= '0;
         wordIdx  <= '0;
         loadLenQ <= '0;
         asmWord  <= '0;
         addrQ    <= '0;
         dataQ    <= '0;
         errorQ   <= 1'b0;
      end else begin
         if (startOk) begin
            if (lenTooBig) begin
               errorQ <= 1'b1;
            end else begin
               errorQ   <= 1'b0;
               byteIdx  <= '0;
               wordIdx  <= '0;
               loadLenQ <= load_len;
            end
         end

         if (state == RECV && abort) begin
            byteIdx <= '0;
         end else if (xfer) begin
            byteIdx <= byteIdx + 2'd1;
            // The fourth byte goes straight into the output word, so the
            // write data is already stable for the whole WRITE cycle.
            unique case (byteIdx)
               2'd0: asmWord[7:0]   <= byte_data;
               2'd1: asmWord[15:8]  <= byte_data;
               2'd2: asmWord[23:16] <= byte_data;
               2'd3: begin
                  dataQ <= {byte_data, asmWord};
                  addrQ <= N'({wordIdx, 2'b00});
               end
               default: ;
            endcase
         end

         if (state == WRITE && !abort && !lastWord)
            wordIdx <= wordIdx + LW'(1);
      end
   end

   assign byte_ready  = (state == RECV);
   assign mem_we      = (state == WRITE);
   assign mem_address = addrQ;
   assign mem_wdata   = dataQ;
   assign busy        = (state == RECV) || (state == WRITE);
   assign done        = (state == DONE);
   assign cpu_hold    = (state != DONE);
   assign error       = errorQ;

endmodule
